// File: rtl/swc_pkg.sv
// Shared store-path types: size codes, default geometry and lane-mask helpers.
package swc_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // Byte-enable pattern for an access of the given size, before lane shifting.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (size_e'(sz))
      SZ_BYTE:  m = 8'h01;
      SZ_HALF:  m = 8'h03;
      SZ_WORD:  m = 8'h0F;
      default:  m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [7:0] align_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (size_e'(sz))
      SZ_BYTE:  m = 8'h00;
      SZ_HALF:  m = 8'h01;
      SZ_WORD:  m = 8'h03;
      default:  m = 8'h07;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/swc_sync_fifo.sv
// Single-clock FIFO with flush; pointers wrap naturally since Depth is a power of two.
module swc_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             hclk,
  input  logic             hrstn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage is never observed while empty, so it needs no reset.
  always_ff @(posedge hclk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/exu_store_queue.sv
// Store queue between decode and MAU: address generation, lane alignment, FIFO buffering.
// Define STORE_MISALIGN_CHK_EN to reject misaligned stores with a misalign_err pulse.
module exu_store_queue
  import swc_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              hclk,
  input  logic              hrstn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_base,
  input  logic [XLEN-1:0]   req_data,
  input  logic [11:0]       req_imm,
  output logic              mau_valid,
  input  logic              mau_ready,
  output logic [XLEN-1:0]   mau_addr,
  output logic [XLEN-1:0]   mau_wdata,
  output logic [XLEN/8-1:0] mau_wstrb,
  output logic [1:0]        mau_size,
  output logic              misalign_err,
  output logic              q_empty
);

  localparam int unsigned NB  = XLEN / 8;
  localparam int unsigned OW  = $clog2(NB);
  localparam int unsigned EW  = 2 * XLEN + NB + 2;
  localparam bit          HasDword = (XLEN == 64);

  logic [XLEN-1:0] w_ea;
  logic [7:0]      w_amask8;
  logic [OW-1:0]   w_amask;
  logic            w_misalign;
  logic [XLEN-1:0] w_addr;
  logic [OW-1:0]   w_off;
  logic [15:0]     w_strb_wide;
  logic [NB-1:0]   w_wstrb;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_wdata;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [EW-1:0]   w_head;

  assign w_ea       = req_base + {{(XLEN-12){req_imm[11]}}, req_imm};
  assign w_amask8   = align_mask(req_size);
  assign w_amask    = w_amask8[OW-1:0];
  assign w_misalign = (|(w_ea[OW-1:0] & w_amask)) | ((req_size == SZ_DWORD) & ~HasDword);
  assign w_accept   = req_valid & req_ready;

`ifdef STORE_MISALIGN_CHK_EN
  logic r_misalign_err;

  assign w_addr = w_ea;
  assign w_push = w_accept & ~flush & ~w_misalign;

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) r_misalign_err <= 1'b0;
    else        r_misalign_err <= w_accept & w_misalign;
  end
  assign misalign_err = r_misalign_err;
`else
  // Force natural alignment instead of trapping.
  assign w_addr       = {w_ea[XLEN-1:OW], w_ea[OW-1:0] & ~w_amask};
  assign w_push       = w_accept & ~flush;
  assign misalign_err = 1'b0;
`endif

  assign w_off       = w_addr[OW-1:0];
  assign w_strb_wide = {8'h00, size_mask(req_size)} << w_off;
  assign w_wstrb     = w_strb_wide[NB-1:0];
  assign w_shifted   = req_data << {w_off, 3'b000};

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < int'(NB); i++) begin
      w_wdata[8*i +: 8] = w_wstrb[i] ? w_shifted[8*i +: 8] : 8'h00;
    end
  end

  swc_sync_fifo #(
    .Width (EW),
    .Depth (DEPTH)
  ) u_fifo (
    .hclk    (hclk),
    .hrstn   (hrstn),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  ({w_addr, w_wdata, w_wstrb, req_size}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready = ~w_full;
  assign mau_valid = ~w_empty;
  assign q_empty   = w_empty;
  assign w_pop     = mau_valid & mau_ready;

  // Payload is zeroed while empty so reset values appear without resetting storage.
  assign mau_addr  = w_empty ? '0 : w_head[EW-1 -: XLEN];
  assign mau_wdata = w_empty ? '0 : w_head[NB+2 +: XLEN];
  assign mau_wstrb = w_empty ? '0 : w_head[2 +: NB];
  assign mau_size  = w_empty ? '0 : w_head[1:0];

endmodule

// File: doc/exu_store_queue.md
EXU_STORE_QUEUE -- requirements
Module: exu_store_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width, legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, store-queue entries, power of two, 2..16.
REQ-003 SHALL have port hclk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port hrstn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  in  1  discard all queued stores.
REQ-006 SHALL have port req_valid  in  1  decoder store request valid.
REQ-007 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_size  in  2  0 byte, 1 halfword, 2 word, 3 doubleword.
REQ-009 SHALL have port req_base  in  XLEN  rs1 value.
REQ-010 SHALL have port req_data  in  XLEN  rs2 value.
REQ-011 SHALL have port req_imm  in  12  S-type immediate.
REQ-012 SHALL have port mau_valid  out  1  store presented to MAU.
REQ-013 SHALL have port mau_ready  in  1  MAU accepts the store.
REQ-014 SHALL have port mau_addr  out  XLEN  effective byte address.
REQ-015 SHALL have port mau_wdata  out  XLEN  lane-aligned write data.
REQ-016 SHALL have port mau_wstrb  out  XLEN/8  byte strobes.
REQ-017 SHALL have port mau_size  out  2  size code of the presented store.
REQ-018 SHALL have port misalign_err  out  1  one-cycle misaligned-store pulse.
REQ-019 SHALL have port q_empty  out  1  high when no store is queued.

Function
REQ-020 Effective address SHALL be req_base + sign-extended req_imm, truncated modulo 2^XLEN.
REQ-021 Strobes SHALL be the size mask (1, 3, 0xF or 0xFF bytes) shifted left by addr[log2(XLEN/8)-1:0].
REQ-022 mau_wdata SHALL be req_data shifted left by 8 x the address byte offset; unstrobed lanes SHALL be zero.
REQ-023 req_size 3 with XLEN 32 SHALL be treated as misaligned.
REQ-024 A store is misaligned when the address is not a multiple of 2^req_size.
REQ-025 Accepted aligned stores SHALL enter a FIFO of DEPTH entries holding addr, wdata, wstrb and size.
REQ-026 req_ready SHALL equal (not full); flush SHALL NOT gate req_ready.
REQ-027 mau_valid SHALL equal (not empty); the head entry SHALL drive the mau_* outputs.
REQ-028 Latency: a store accepted into an empty queue at edge N SHALL present mau_valid after edge N.
REQ-029 Once raised, mau_valid and the payload SHALL hold stable until the cycle mau_ready is high.
REQ-030 A same-cycle push and pop SHALL leave the occupancy unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-031 flush SHALL empty the queue at the next edge. A handshake in the flush cycle counts as complete. A request accepted in the flush cycle SHALL be dropped.
REQ-032 q_empty SHALL equal (occupancy == 0).

Reset
REQ-033 On hrstn low, pointers and occupancy SHALL clear immediately.
REQ-034 During reset: mau_valid=0, mau_addr=0, mau_wdata=0, mau_wstrb=0, mau_size=0, misalign_err=0, req_ready=1, q_empty=1.
REQ-035 Reset mid-handshake SHALL drop all entries; there SHALL be no replay after reset is released.

Configuration
REQ-036 Macro STORE_MISALIGN_CHK_EN defined: a misaligned request is accepted, is not enqueued, and raises misalign_err for one cycle after acceptance.
REQ-037 Macro undefined: misalign_err is tied to 0, address low bits are cleared to size alignment, and the store is enqueued.

Structure
REQ-038 Package swc_pkg SHALL hold the size codes (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3) and the XLEN/DEPTH defaults.
REQ-039 Queue storage SHALL be a sub-module swc_sync_fifo (parametrised width/depth, push/pop/flush, full/empty).

Verification
REQ-040 Check a word store: base 0x1000, imm 0x004, data 0xDEADBEEF -> addr 0x1004, wstrb 0xF, wdata 0xDEADBEEF, mau_valid one cycle after accept.
REQ-041 Check a byte store: base 0x2000, imm 0xFFF (-1), data 0xAB -> addr 0x1FFF, wstrb 0x8, wdata 0xAB000000.
REQ-042 Check backpressure: hold mau_ready=0 and push 4 stores (DEPTH 4) -> req_ready low after the 4th; payload stable; raise mau_ready -> in-order drain, q_empty=1.
REQ-043 Check a misaligned halfword at 0x3001 with the macro defined -> misalign_err pulses 1 cycle and nothing is enqueued; with the macro undefined -> addr 0x3000, wstrb 0x3.
REQ-044 Check flush with 3 entries queued and a simultaneous handshake -> head counts as done; q_empty=1 and mau_valid=0 after the next edge.
REQ-045 Check hrstn asserted with 2 entries queued -> all outputs immediately take reset values; queue empty after release.
